// File: rtl/gray_counter_updown.sv
// Registered Gray-code up/down counter with load, wrap/saturate mode, terminal-count
// and saturation pulses, plus a combinational binary decode of the count register.
module gray_counter_updown #(
  parameter int WIDTH    = 16,
  parameter int SPEED    = 2,
  parameter int SATURATE = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] D_i,
  output logic [WIDTH-1:0] Z_o,
  output logic [WIDTH-1:0] B_o,
  output logic             tc_o,
  output logic             sat_o
);
  localparam int L = $clog2(WIDTH);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             par_q, par_d;
  logic             tc_q, tc_d;
  logic             sat_q, sat_d;

  logic [WIDTH-1:0] zb, pre, nb, lsb, flip, mask;
  logic             top, zero, wrap, blocked;

  // pre[i] = no bit of cnt_q set at or below position i
  assign zb = ~cnt_q;

  generate
    if (SPEED == 0) begin : g_serial
      logic [WIDTH-1:0] ch;
      always_comb begin
        logic acc;
        acc = 1'b1;
        ch  = '0;
        for (int i = 0; i < WIDTH; i++) begin
          acc   = acc & zb[i];
          ch[i] = acc;
        end
      end
      assign pre = ch;
    end else if (SPEED == 1) begin : g_bk
      // Up-sweep over stages 1..L, down-sweep over stages L+1..2L-1
      for (genvar s = 0; s < 2*L; s++) begin : g_st
        logic [WIDTH-1:0] v;
        if (s == 0) begin : g_in
          assign v = zb;
        end else begin : g_lvl
          localparam int K  = (s <= L) ? s - 1 : 2*L - 1 - s;
          localparam int SP = 2**K;
          for (genvar i = 0; i < WIDTH; i++) begin : g_b
            if ((s <= L) ? ((i + 1) % (2*SP) == 0)
                         : ((i >= 2*SP) && ((i + 1 - SP) % (2*SP) == 0))) begin : g_op
              assign v[i] = g_st[s-1].v[i] & g_st[s-1].v[i-SP];
            end else begin : g_pass
              assign v[i] = g_st[s-1].v[i];
            end
          end
        end
      end
      assign pre = g_st[2*L-1].v;
    end else begin : g_sk
      for (genvar s = 0; s <= L; s++) begin : g_st
        logic [WIDTH-1:0] v;
        if (s == 0) begin : g_in
          assign v = zb;
        end else begin : g_lvl
          localparam int K = s - 1;
          for (genvar i = 0; i < WIDTH; i++) begin : g_b
            if (((i >> K) % 2) == 1) begin : g_op
              assign v[i] = g_st[s-1].v[i] & g_st[s-1].v[((i >> K) << K) - 1];
            end else begin : g_pass
              assign v[i] = g_st[s-1].v[i];
            end
          end
        end
      end
      assign pre = g_st[L].v;
    end
  endgenerate

  assign nb   = {pre[WIDTH-2:0], 1'b1};
  assign lsb  = cnt_q & nb;
  assign flip = {lsb[WIDTH-2:0], 1'b0};
  assign top  = lsb[WIDTH-1];
  assign zero = pre[WIDTH-1];
  assign wrap = up_i ? top : zero;
  assign blocked = (SATURATE != 0) && wrap;

  // Both wrap cases (100..0 -> 0 up, 0 -> 100..0 down) are a single MSB flip.
  assign mask = (up_i ^ par_q) ? WIDTH'(1)
                               : (flip | {top | zero, {(WIDTH-1){1'b0}}});

  always_comb begin
    cnt_d = cnt_q;
    par_d = par_q;
    tc_d  = 1'b0;
    sat_d = 1'b0;
    if (load_i) begin
      cnt_d = D_i;
      par_d = ^D_i;
    end else if (en_i) begin
      if (blocked) begin
        sat_d = 1'b1;
      end else begin
        cnt_d = cnt_q ^ mask;
        par_d = ~par_q;
        tc_d  = wrap;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      par_q <= 1'b0;
      tc_q  <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      par_q <= par_d;
      tc_q  <= tc_d;
      sat_q <= sat_d;
    end
  end

  always_comb begin
    logic acc;
    acc = 1'b0;
    B_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc    = acc ^ cnt_q[i];
      B_o[i] = acc;
    end
  end

  assign Z_o   = cnt_q;
  assign tc_o  = tc_q;
  assign sat_o = sat_q;
endmodule

// File: tb/tb_gray_counter_updown.sv
// Scoreboard bench: five counters (two 4-bit, three 8-bit, mixed SPEED/SATURATE)
// share one stimulus stream and are checked against a binary-arithmetic model.
module tb_gray_counter_updown;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, en = 1'b0, up = 1'b0, load = 1'b0;
  logic [7:0] d = '0;
  logic [3:0] z0, b0, z1, b1;
  logic [7:0] z2, b2, z3, b3, z4, b4;
  logic [4:0] tc, sat;

  gray_counter_updown #(.WIDTH(4), .SPEED(2), .SATURATE(0)) u0 (.clk_i(clk), .rst_i(rst), .en_i(en),
    .up_i(up), .load_i(load), .D_i(d[3:0]), .Z_o(z0), .B_o(b0), .tc_o(tc[0]), .sat_o(sat[0]));
  gray_counter_updown #(.WIDTH(4), .SPEED(0), .SATURATE(1)) u1 (.clk_i(clk), .rst_i(rst), .en_i(en),
    .up_i(up), .load_i(load), .D_i(d[3:0]), .Z_o(z1), .B_o(b1), .tc_o(tc[1]), .sat_o(sat[1]));
  gray_counter_updown #(.WIDTH(8), .SPEED(0), .SATURATE(0)) u2 (.clk_i(clk), .rst_i(rst), .en_i(en),
    .up_i(up), .load_i(load), .D_i(d), .Z_o(z2), .B_o(b2), .tc_o(tc[2]), .sat_o(sat[2]));
  gray_counter_updown #(.WIDTH(8), .SPEED(1), .SATURATE(1)) u3 (.clk_i(clk), .rst_i(rst), .en_i(en),
    .up_i(up), .load_i(load), .D_i(d), .Z_o(z3), .B_o(b3), .tc_o(tc[3]), .sat_o(sat[3]));
  gray_counter_updown #(.WIDTH(8), .SPEED(2), .SATURATE(0)) u4 (.clk_i(clk), .rst_i(rst), .en_i(en),
    .up_i(up), .load_i(load), .D_i(d), .Z_o(z4), .B_o(b4), .tc_o(tc[4]), .sat_o(sat[4]));

  logic [4:0][7:0] zz, bb;
  assign zz = {z4, z3, z2, {4'h0, z1}, {4'h0, z0}};
  assign bb = {b4, b3, b2, {4'h0, b1}, {4'h0, b0}};

  localparam int WD [5] = '{4, 4, 8, 8, 8};
  localparam int SD [5] = '{0, 1, 0, 1, 0};

  typedef struct packed {
    logic [4:0][7:0] z;
    logic [4:0][7:0] b;
    logic [4:0]      tc;
    logic [4:0]      sat;
    logic            jump;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned mb [5];

  function automatic int unsigned g2b(input int unsigned g);
    int unsigned r;
    r = 0;
    for (int k = 0; k < 8; k++) r ^= g >> k;
    return r;
  endfunction

  // Drive one cycle of inputs and push what every counter must show after the next edge.
  task automatic drive(input logic r, input logic l, input logic e, input logic u,
                       input logic [7:0] dv);
    exp_t x;
    int unsigned m;
    @(negedge clk);
    #1;
    rst = r; load = l; en = e; up = u; d = dv;
    x = '0;
    x.jump = r | l;
    for (int i = 0; i < 5; i++) begin
      m = (1 << WD[i]) - 1;
      if (r) mb[i] = 0;
      else if (l) mb[i] = g2b(int'(dv) & m);
      else if (e) begin
        if (u) begin
          if (mb[i] == m) begin
            if (SD[i] != 0) x.sat[i] = 1'b1;
            else begin mb[i] = 0; x.tc[i] = 1'b1; end
          end else mb[i] = mb[i] + 1;
        end else begin
          if (mb[i] == 0) begin
            if (SD[i] != 0) x.sat[i] = 1'b1;
            else begin mb[i] = m; x.tc[i] = 1'b1; end
          end else mb[i] = mb[i] - 1;
        end
      end
      x.b[i] = 8'(mb[i]);
      x.z[i] = 8'(mb[i] ^ (mb[i] >> 1));
    end
    q.push_back(x);
  endtask

  // Monitor: every cycle is an output; pop one expectation per negedge.
  initial begin
    exp_t x;
    logic [4:0][7:0] pz;
    pz = '0;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        for (int i = 0; i < 5; i++) begin
          checks++;
          if (zz[i] !== x.z[i] || bb[i] !== x.b[i] || tc[i] !== x.tc[i] || sat[i] !== x.sat[i]) begin
            failures++;
            $display("FAIL state dut%0d t=%0t: Z=%h B=%h tc=%b sat=%b, want Z=%h B=%h tc=%b sat=%b",
                     i, $time, zz[i], bb[i], tc[i], sat[i], x.z[i], x.b[i], x.tc[i], x.sat[i]);
          end
          if (!x.jump) begin
            checks++;
            if ($countones(zz[i] ^ pz[i]) > 1) begin
              failures++;
              $display("FAIL onebit dut%0d t=%0t: Z %h -> %h, want at most one bit changed",
                       i, $time, pz[i], zz[i]);
            end
          end
        end
        pz = zz;
      end
    end
  end

  initial begin
    logic [7:0] dv;
    for (int i = 0; i < 5; i++) mb[i] = 0;
    // Reset with en held high
    drive(1, 0, 1, 1, 8'h00);
    drive(1, 0, 1, 1, 8'h00);
    // Full up lap (4-bit wraps on the 16th step)
    for (int k = 0; k < 16; k++) drive(0, 0, 1, 1, 8'h00);
    // Down from the 4-bit zero, then once more
    drive(1, 0, 0, 0, 8'h00);
    drive(0, 0, 1, 0, 8'h00);
    drive(0, 0, 1, 0, 8'h00);
    // Load 0110 with en high, then up, then down
    drive(0, 1, 1, 1, 8'h06);
    drive(0, 0, 1, 1, 8'h00);
    drive(0, 0, 1, 0, 8'h00);
    // Climb to the 4-bit top and push against it, then hold
    drive(1, 0, 0, 0, 8'h00);
    for (int k = 0; k < 18; k++) drive(0, 0, 1, 1, 8'h00);
    drive(0, 0, 0, 1, 8'h00);
    // Push below zero
    drive(1, 0, 0, 0, 8'h00);
    drive(0, 0, 1, 0, 8'h00);
    drive(0, 0, 1, 0, 8'h00);
    // 8-bit ends via loads
    drive(0, 1, 0, 0, 8'h80);
    drive(0, 0, 1, 1, 8'h00);
    drive(0, 0, 1, 1, 8'h00);
    drive(0, 1, 0, 0, 8'h00);
    drive(0, 0, 1, 0, 8'h00);
    // Random run with a guaranteed mid-run reset
    for (int k = 0; k < 600; k++) begin
      case ($urandom_range(0, 3))
        0: dv = 8'h00;
        1: dv = 8'h80;
        2: dv = 8'h08;
        default: dv = 8'($urandom);
      endcase
      drive((k == 300) || ($urandom_range(0, 59) == 0), $urandom_range(0, 9) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, dv);
    end
    drive(0, 0, 0, 0, 8'h00);
    for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
